// File: rtl/ahbarb_pkg.sv
// Shared types, HTRANS encodings and burst-length helper for the dual-master AHB arbiter.
package ahbarb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Data-phase owner encoding
    localparam logic [1:0] DOWN_NONE = 2'b00;
    localparam logic [1:0] DOWN_M0   = 2'b01;
    localparam logic [1:0] DOWN_M1   = 2'b10;

    // Beats remaining after the first (NONSEQ) beat of a fixed-length burst.
    // Undefined-length INCR is not tracked: it never forces grant retention.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            3'b010, 3'b011: burst_beats = 4'd3;   // WRAP4 / INCR4
            3'b100, 3'b101: burst_beats = 4'd7;   // WRAP8 / INCR8
            3'b110, 3'b111: burst_beats = 4'd15;  // WRAP16 / INCR16
            default:        burst_beats = 4'd0;   // SINGLE / INCR
        endcase
    endfunction

endpackage

// File: rtl/ahb_master_input_stage.sv
// Per-master address-phase hold register. A request that cannot be issued this
// cycle (not granted, or slave stalling) is captured and replayed from the copy.
module ahb_master_input_stage
    import ahbarb_pkg::*;
#(
    parameter int PA_BITS = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [PA_BITS-1:0] haddr_i,
    input  logic [1:0]         htrans_i,
    input  logic               hwrite_i,
    input  logic [2:0]         hsize_i,
    input  logic [2:0]         hburst_i,
    input  logic [3:0]         hprot_i,
    input  logic               hmastlock_i,
    input  logic               grant_i,
    input  logic               hready_i,
    output logic [PA_BITS-1:0] haddr_o,
    output logic [1:0]         htrans_o,
    output logic               hwrite_o,
    output logic [2:0]         hsize_o,
    output logic [2:0]         hburst_o,
    output logic [3:0]         hprot_o,
    output logic               hmastlock_o,
    output logic               req_o
);

    localparam int AW = PA_BITS + 14;

    logic [AW-1:0] live, eff, held_q, held_d;
    logic          held_valid_q, held_valid_d;
    logic          accepted;

    assign live     = {haddr_i, htrans_i, hwrite_i, hsize_i, hburst_i, hprot_i, hmastlock_i};
    assign eff      = held_valid_q ? held_q : live;
    assign {haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o, hmastlock_o} = eff;
    assign req_o    = htrans_o[1];
    assign accepted = grant_i && hready_i;

    // Capture a stalled request; release once the held copy is accepted
    always_comb begin
        held_valid_d = held_valid_q;
        held_d       = held_q;
        if (held_valid_q) begin
            if (accepted) held_valid_d = 1'b0;
        end else if (htrans_i[1] && !accepted) begin
            held_valid_d = 1'b1;
            held_d       = live;
        end
    end

    // Hold register; a capture in flight at reset is dropped
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held_valid_q <= 1'b0;
            held_q       <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            held_q       <= held_d;
        end
    end

endmodule

// File: rtl/ahb_dual_master_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter with burst/lock grant retention.
// Optional: AHBARB_ROUND_ROBIN_EN switches contention from fixed priority
// (M1 over M0) to alternating priority based on the most recent owner.
module ahb_dual_master_arbiter
    import ahbarb_pkg::*;
#(
    parameter int PA_BITS = 32,
    parameter int AHBW    = 64
) (
    input  logic                HCLK,
    input  logic                reset,
    input  logic [PA_BITS-1:0]  M0_HADDR,
    input  logic [1:0]          M0_HTRANS,
    input  logic                M0_HWRITE,
    input  logic [2:0]          M0_HSIZE,
    input  logic [2:0]          M0_HBURST,
    input  logic [3:0]          M0_HPROT,
    input  logic                M0_HMASTLOCK,
    input  logic [AHBW-1:0]     M0_HWDATA,
    input  logic [AHBW/8-1:0]   M0_HWSTRB,
    output logic                M0_HREADY,
    output logic                M0_HRESP,
    output logic [AHBW-1:0]     M0_HRDATA,
    input  logic [PA_BITS-1:0]  M1_HADDR,
    input  logic [1:0]          M1_HTRANS,
    input  logic                M1_HWRITE,
    input  logic [2:0]          M1_HSIZE,
    input  logic [2:0]          M1_HBURST,
    input  logic [3:0]          M1_HPROT,
    input  logic                M1_HMASTLOCK,
    input  logic [AHBW-1:0]     M1_HWDATA,
    input  logic [AHBW/8-1:0]   M1_HWSTRB,
    output logic                M1_HREADY,
    output logic                M1_HRESP,
    output logic [AHBW-1:0]     M1_HRDATA,
    output logic [PA_BITS-1:0]  HADDR,
    output logic [1:0]          HTRANS,
    output logic                HWRITE,
    output logic [2:0]          HSIZE,
    output logic [2:0]          HBURST,
    output logic [3:0]          HPROT,
    output logic                HMASTLOCK,
    output logic [AHBW-1:0]     HWDATA,
    output logic [AHBW/8-1:0]   HWSTRB,
    input  logic                HREADY,
    input  logic                HRESP,
    input  logic [AHBW-1:0]     HRDATA
);

    // Effective (held or live) address phase per master
    logic [PA_BITS-1:0] e0_addr, e1_addr;
    logic [1:0]         e0_trans, e1_trans;
    logic               e0_write, e1_write;
    logic [2:0]         e0_size, e1_size, e0_burst, e1_burst;
    logic [3:0]         e0_prot, e1_prot;
    logic               e0_lock, e1_lock, e0_req, e1_req;

    arb_state_t state_q, state_d;
    logic [3:0] beats_q, beats_d;
    logic [1:0] down_q, down_d;
    logic       owner_hold, pick1;
    logic [1:0] sel_trans;

    ahb_master_input_stage #(.PA_BITS(PA_BITS)) u_stage0 (
        .clk_i(HCLK), .reset_i(reset),
        .haddr_i(M0_HADDR), .htrans_i(M0_HTRANS), .hwrite_i(M0_HWRITE), .hsize_i(M0_HSIZE),
        .hburst_i(M0_HBURST), .hprot_i(M0_HPROT), .hmastlock_i(M0_HMASTLOCK),
        .grant_i(state_d == OWN0), .hready_i(HREADY),
        .haddr_o(e0_addr), .htrans_o(e0_trans), .hwrite_o(e0_write), .hsize_o(e0_size),
        .hburst_o(e0_burst), .hprot_o(e0_prot), .hmastlock_o(e0_lock), .req_o(e0_req)
    );

    ahb_master_input_stage #(.PA_BITS(PA_BITS)) u_stage1 (
        .clk_i(HCLK), .reset_i(reset),
        .haddr_i(M1_HADDR), .htrans_i(M1_HTRANS), .hwrite_i(M1_HWRITE), .hsize_i(M1_HSIZE),
        .hburst_i(M1_HBURST), .hprot_i(M1_HPROT), .hmastlock_i(M1_HMASTLOCK),
        .grant_i(state_d == OWN1), .hready_i(HREADY),
        .haddr_o(e1_addr), .htrans_o(e1_trans), .hwrite_o(e1_write), .hsize_o(e1_size),
        .hburst_o(e1_burst), .hprot_o(e1_prot), .hmastlock_o(e1_lock), .req_o(e1_req)
    );

`ifdef AHBARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign pick1 = ~last_q;

    // Remember who drove the address bus most recently
    always_comb begin
        last_d = last_q;
        if (HREADY && state_d != IDLE) last_d = (state_d == OWN1);
    end

    // LastOwner register; starts as M1 so M0 wins the first contention
    always_ff @(posedge HCLK) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end
`else
    assign pick1 = 1'b1;
`endif

    // Grant: state_d is the owner driving the address bus this cycle. It only
    // moves on HREADY=1 so the address phase stays stable across wait states.
    // An owner that cancels its burst with IDLE releases the bus immediately.
    always_comb begin
        state_d    = state_q;
        owner_hold = 1'b0;
        if (state_q == OWN0)
            owner_hold = ((beats_q != 4'd0) && (e0_trans != HTRANS_IDLE)) || e0_lock;
        else if (state_q == OWN1)
            owner_hold = ((beats_q != 4'd0) && (e1_trans != HTRANS_IDLE)) || e1_lock;
        if (reset) begin
            state_d = IDLE;
        end else if (HREADY && !owner_hold) begin
            if (e0_req && e1_req) state_d = pick1 ? OWN1 : OWN0;
            else if (e1_req)      state_d = OWN1;
            else if (e0_req)      state_d = OWN0;
            else                  state_d = IDLE;
        end
    end

    // Grant state register
    always_ff @(posedge HCLK) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Slave-side address mux; a new owner always opens with NONSEQ
    always_comb begin
        HADDR     = e0_addr;
        sel_trans = e0_trans;
        HWRITE    = e0_write;
        HSIZE     = e0_size;
        HBURST    = e0_burst;
        HPROT     = e0_prot;
        HMASTLOCK = e0_lock;
        if (state_d == OWN1) begin
            HADDR     = e1_addr;
            sel_trans = e1_trans;
            HWRITE    = e1_write;
            HSIZE     = e1_size;
            HBURST    = e1_burst;
            HPROT     = e1_prot;
            HMASTLOCK = e1_lock;
        end
        HTRANS = sel_trans;
        if (state_d == IDLE)
            HTRANS = HTRANS_IDLE;
        else if (state_d != state_q)
            HTRANS = sel_trans[1] ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    // Burst beat counter and data-phase owner, both advance on accepted address phases
    always_comb begin
        beats_d = beats_q;
        down_d  = down_q;
        if (HREADY) begin
            case (HTRANS)
                HTRANS_NONSEQ: beats_d = burst_beats(HBURST);
                HTRANS_SEQ:    beats_d = (beats_q == 4'd0) ? 4'd0 : beats_q - 4'd1;
                HTRANS_BUSY:   beats_d = beats_q;
                default:       beats_d = 4'd0;
            endcase
            down_d = DOWN_NONE;
            if (HTRANS[1]) down_d = (state_d == OWN1) ? DOWN_M1 : DOWN_M0;
        end
    end

    // Burst and data-phase registers
    always_ff @(posedge HCLK) begin
        if (reset) begin
            beats_q <= 4'd0;
            down_q  <= DOWN_NONE;
        end else begin
            beats_q <= beats_d;
            down_q  <= down_d;
        end
    end

    // Data-phase routing: write data from, and response to, the data owner only.
    // A requesting master stalls until its own address phase is accepted.
    always_comb begin
        HWDATA    = '0;
        HWSTRB    = '0;
        M0_HRDATA = '0;
        M1_HRDATA = '0;
        M0_HRESP  = 1'b0;
        M1_HRESP  = 1'b0;
        M0_HREADY = 1'b1;
        M1_HREADY = 1'b1;
        if (down_q == DOWN_M0) begin
            HWDATA = M0_HWDATA;
            HWSTRB = M0_HWSTRB;
        end else if (down_q == DOWN_M1) begin
            HWDATA = M1_HWDATA;
            HWSTRB = M1_HWSTRB;
        end
        if (!reset) begin
            if (down_q == DOWN_M0) begin
                M0_HRDATA = HRDATA;
                M0_HRESP  = HRESP;
                M0_HREADY = HREADY;
            end
            if (down_q == DOWN_M1) begin
                M1_HRDATA = HRDATA;
                M1_HRESP  = HRESP;
                M1_HREADY = HREADY;
            end
            if (e0_req) M0_HREADY = (state_d == OWN0) && HREADY;
            if (e1_req) M1_HREADY = (state_d == OWN1) && HREADY;
        end
    end

endmodule

// File: tb/tb_ahb_dual_master_arbiter.sv
// Directed bench for ahb_dual_master_arbiter: reset, single transfer, collision,
// burst retention, locked sequence, error routing and reset mid-burst.
module tb_ahb_dual_master_arbiter;

    localparam logic [1:0] T_IDLE = 2'b00, T_NS = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR4 = 3'b011, B_INCR8 = 3'b101;

    logic        HCLK = 1'b0;
    logic        reset;
    logic [31:0] M0_HADDR, M1_HADDR, HADDR;
    logic [1:0]  M0_HTRANS, M1_HTRANS, HTRANS;
    logic        M0_HWRITE, M1_HWRITE, HWRITE;
    logic [2:0]  M0_HSIZE, M1_HSIZE, HSIZE, M0_HBURST, M1_HBURST, HBURST;
    logic [3:0]  M0_HPROT, M1_HPROT, HPROT;
    logic        M0_HMASTLOCK, M1_HMASTLOCK, HMASTLOCK;
    logic [63:0] M0_HWDATA, M1_HWDATA, HWDATA, M0_HRDATA, M1_HRDATA, HRDATA;
    logic [7:0]  M0_HWSTRB, M1_HWSTRB, HWSTRB;
    logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP, HREADY, HRESP;

    int checks = 0;
    int errors = 0;

    ahb_dual_master_arbiter #(.PA_BITS(32), .AHBW(64)) dut (
        .HCLK(HCLK), .reset(reset),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
        .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK),
        .M0_HWDATA(M0_HWDATA), .M0_HWSTRB(M0_HWSTRB),
        .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
        .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK),
        .M1_HWDATA(M1_HWDATA), .M1_HWSTRB(M1_HWSTRB),
        .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    initial forever #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge
    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv0(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] b, input logic l);
        M0_HADDR = a; M0_HTRANS = t; M0_HWRITE = w; M0_HBURST = b; M0_HMASTLOCK = l;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [1:0] t, input logic w,
                        input logic [2:0] b, input logic l);
        M1_HADDR = a; M1_HTRANS = t; M1_HWRITE = w; M1_HBURST = b; M1_HMASTLOCK = l;
    endtask

    initial begin
        reset = 1'b1;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 64'h0;
        M0_HSIZE = 3'b011; M1_HSIZE = 3'b011; M0_HPROT = 4'b0011; M1_HPROT = 4'b0011;
        M0_HWSTRB = 8'hFF; M1_HWSTRB = 8'hFF; M0_HWDATA = 64'h0; M1_HWDATA = 64'h0;
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        nxt(); nxt();

        // Reset held: live request and slave data must not leak out
        HRDATA = 64'hDEAD_BEEF_0000_0001;
        drv0(32'h8000_0000, T_NS, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_m0_hready", M0_HREADY, 1'b1);
        chk("rst_m1_hready", M1_HREADY, 1'b1);
        chk("rst_m0_hresp", M0_HRESP, 1'b0);
        chk("rst_m0_hrdata", M0_HRDATA, 64'h0);
        chk("rst_m1_hrdata", M1_HRDATA, 64'h0);
        nxt();
        reset = 1'b0; HRDATA = 64'h0;
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("post_rst_htrans", HTRANS, 2'b00);

`ifdef AHBARB_ROUND_ROBIN_EN
        // Alternating contention: M0, M1, M0
        nxt();
        drv0(32'h1000, T_NS, 1'b1, B_SINGLE, 1'b0);
        drv1(32'h2000, T_NS, 1'b1, B_SINGLE, 1'b0);
        #1;
        chk("rr1_haddr", HADDR, 32'h1000);
        chk("rr1_m1_hready", M1_HREADY, 1'b0);
        nxt();
        drv0(32'h1008, T_NS, 1'b1, B_SINGLE, 1'b0);
        #1;
        chk("rr2_haddr", HADDR, 32'h2000);
        chk("rr2_m0_hready", M0_HREADY, 1'b0);
        nxt();
        drv1(32'h2008, T_NS, 1'b1, B_SINGLE, 1'b0);
        #1;
        chk("rr3_haddr", HADDR, 32'h1008);
        chk("rr3_m1_hready", M1_HREADY, 1'b0);
        nxt();
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("rr4_haddr", HADDR, 32'h2008);
        nxt();
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("rr5_htrans", HTRANS, 2'b00);
`endif

        // Single master read
        nxt();
        drv0(32'h8000_0000, T_NS, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("s_haddr", HADDR, 32'h8000_0000);
        chk("s_htrans", HTRANS, 2'b10);
        chk("s_hwrite", HWRITE, 1'b0);
        chk("s_m0_hready", M0_HREADY, 1'b1);
        chk("s_m1_hready", M1_HREADY, 1'b1);
        nxt();
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        HRDATA = 64'h1122_3344_5566_7788;
        #1;
        chk("s_m0_hrdata", M0_HRDATA, 64'h1122_3344_5566_7788);
        chk("s_m1_hrdata", M1_HRDATA, 64'h0);
        chk("s_m1_hready_d", M1_HREADY, 1'b1);
        chk("s_htrans_idle", HTRANS, 2'b00);

`ifndef AHBARB_ROUND_ROBIN_EN
        // Collision: M1 first, M0 replayed next cycle
        nxt();
        HRDATA = 64'h0;
        drv0(32'h1000, T_NS, 1'b1, B_SINGLE, 1'b0);
        drv1(32'h2000, T_NS, 1'b1, B_SINGLE, 1'b0);
        #1;
        chk("c_haddr", HADDR, 32'h2000);
        chk("c_htrans", HTRANS, 2'b10);
        chk("c_m0_hready", M0_HREADY, 1'b0);
        chk("c_m1_hready", M1_HREADY, 1'b1);
        nxt();
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        M1_HWDATA = 64'hAAAA;
        #1;
        chk("c_held_haddr", HADDR, 32'h1000);
        chk("c_held_htrans", HTRANS, 2'b10);
        chk("c_held_hwrite", HWRITE, 1'b1);
        chk("c_m1_hwdata", HWDATA, 64'hAAAA);
        chk("c_m0_hready_rel", M0_HREADY, 1'b1);
        nxt();
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        M0_HWDATA = 64'hBBBB;
        #1;
        chk("c_m0_hwdata", HWDATA, 64'hBBBB);
        chk("c_htrans_idle", HTRANS, 2'b00);
`endif

        // INCR4 burst keeps the grant against M1
        nxt();
        drv0(32'h100, T_NS, 1'b0, B_INCR4, 1'b0);
        #1;
        chk("b1_haddr", HADDR, 32'h100);
        chk("b1_htrans", HTRANS, 2'b10);
        nxt();
        drv0(32'h108, T_SEQ, 1'b0, B_INCR4, 1'b0);
        drv1(32'h3000, T_NS, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("b2_haddr", HADDR, 32'h108);
        chk("b2_htrans", HTRANS, 2'b11);
        chk("b2_m1_hready", M1_HREADY, 1'b0);
        nxt();
        drv0(32'h110, T_SEQ, 1'b0, B_INCR4, 1'b0);
        #1;
        chk("b3_haddr", HADDR, 32'h110);
        chk("b3_m1_hready", M1_HREADY, 1'b0);
        nxt();
        drv0(32'h118, T_SEQ, 1'b0, B_INCR4, 1'b0);
        #1;
        chk("b4_haddr", HADDR, 32'h118);
        chk("b4_htrans", HTRANS, 2'b11);
        chk("b4_m1_hready", M1_HREADY, 1'b0);
        nxt();
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("b5_haddr", HADDR, 32'h3000);
        chk("b5_htrans", HTRANS, 2'b10);
        chk("b5_m1_hready", M1_HREADY, 1'b1);
        nxt();
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("b6_htrans", HTRANS, 2'b00);

        // Locked sequence of two M1 singles keeps M0 out
        nxt();
        drv1(32'h4000, T_NS, 1'b1, B_SINGLE, 1'b1);
        #1;
        chk("l1_haddr", HADDR, 32'h4000);
        chk("l1_hmastlock", HMASTLOCK, 1'b1);
        nxt();
        drv1(32'h4000, T_IDLE, 1'b1, B_SINGLE, 1'b1);
        drv0(32'h5000, T_NS, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("l2_htrans", HTRANS, 2'b00);
        chk("l2_hmastlock", HMASTLOCK, 1'b1);
        chk("l2_m0_hready", M0_HREADY, 1'b0);
        nxt();
        drv1(32'h4008, T_NS, 1'b1, B_SINGLE, 1'b1);
        #1;
        chk("l3_haddr", HADDR, 32'h4008);
        chk("l3_m0_hready", M0_HREADY, 1'b0);
        nxt();
        drv1(32'h4008, T_IDLE, 1'b1, B_SINGLE, 1'b0);
        #1;
        chk("l4_haddr", HADDR, 32'h5000);
        chk("l4_htrans", HTRANS, 2'b10);
        chk("l4_hmastlock", HMASTLOCK, 1'b0);
        chk("l4_m0_hready", M0_HREADY, 1'b1);
        nxt();
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("l5_htrans", HTRANS, 2'b00);

        // Two-cycle ERROR to M1
        nxt();
        drv1(32'h6000, T_NS, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("e0_haddr", HADDR, 32'h6000);
        nxt();
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        HREADY = 1'b0; HRESP = 1'b1;
        #1;
        chk("e1_m1_hresp", M1_HRESP, 1'b1);
        chk("e1_m1_hready", M1_HREADY, 1'b0);
        chk("e1_m0_hresp", M0_HRESP, 1'b0);
        chk("e1_m0_hready", M0_HREADY, 1'b1);
        nxt();
        HREADY = 1'b1; HRESP = 1'b1;
        #1;
        chk("e2_m1_hresp", M1_HRESP, 1'b1);
        chk("e2_m1_hready", M1_HREADY, 1'b1);
        chk("e2_m0_hresp", M0_HRESP, 1'b0);
        nxt();
        HRESP = 1'b0;
        #1;
        chk("e3_m1_hresp", M1_HRESP, 1'b0);

        // Reset in the middle of an INCR8; resumed SEQ goes out as NONSEQ
        nxt();
        drv0(32'h200, T_NS, 1'b0, B_INCR8, 1'b0);
        #1;
        chk("r1_htrans", HTRANS, 2'b10);
        nxt();
        drv0(32'h208, T_SEQ, 1'b0, B_INCR8, 1'b0);
        nxt();
        drv0(32'h210, T_SEQ, 1'b0, B_INCR8, 1'b0);
        drv1(32'h7000, T_NS, 1'b0, B_SINGLE, 1'b0);
        reset = 1'b1;
        #1;
        chk("r3_htrans", HTRANS, 2'b00);
        chk("r3_m0_hready", M0_HREADY, 1'b1);
        chk("r3_m1_hready", M1_HREADY, 1'b1);
        nxt();
        reset = 1'b0;
        drv0(32'h218, T_SEQ, 1'b0, B_INCR8, 1'b0);
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("r4_htrans", HTRANS, 2'b10);
        chk("r4_haddr", HADDR, 32'h218);
        chk("r4_held0", dut.u_stage0.held_valid_q, 1'b0);
        chk("r4_held1", dut.u_stage1.held_valid_q, 1'b0);
        nxt();
        drv0(32'h220, T_SEQ, 1'b0, B_INCR8, 1'b0);
        drv1(32'h7000, T_NS, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("r5_haddr", HADDR, 32'h220);
        chk("r5_htrans", HTRANS, 2'b11);
        chk("r5_m1_hready", M1_HREADY, 1'b0);
        nxt();
        drv0(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        #1;
        chk("r6_haddr", HADDR, 32'h7000);
        chk("r6_m1_hready", M1_HREADY, 1'b1);
        nxt();
        drv1(32'h0, T_IDLE, 1'b0, B_SINGLE, 1'b0);
        nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
